// File: rtl/axil_regfile_responder.sv
// axil_regfile_responder
//   AXI4-Lite slave register file. Register 0 is a read-only ID word,
//   register 1 is a read-only copy of status_in (sampled every cycle), and
//   registers 2..NUM_REGS-1 are read/write control registers with byte
//   strobes. Each committed write to a RW register pulses its wr_pulse bit
//   for one cycle.
//
//   Optional build macro: AXIL_RESP_SLVERR_EN
//     defined   -> out-of-range accesses and writes to registers 0/1 answer
//                  SLVERR (2'b10)
//     undefined -> every response is OKAY (2'b00)
//
// Ports
//   sys_clk, sys_reset          clock, synchronous active-high reset
//   s_axi_aw*/w*/b*             AXI4-Lite write address/data/response
//   s_axi_ar*/r*                AXI4-Lite read address/data
//   status_in   [31:0]          status vector mirrored into register 1
//   reg_out     [NUM_REGS*32]   flat image of all registers, index i at [32*i+:32]
//   wr_pulse    [NUM_REGS]      one-cycle write-commit strobe per register
module axil_regfile_responder #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'h58475341
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [ADDR_W-1:0]      s_axi_awaddr,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  output logic [1:0]             s_axi_bresp,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  input  logic [ADDR_W-1:0]      s_axi_araddr,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  input  logic [31:0]            status_in,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]    wr_pulse
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [31:0]      rw_regs [2:NUM_REGS-1];
  logic [31:0]      status_q;
  logic [31:0]      regs_view [NUM_REGS];

  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;

  logic             commit;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic             wr_in_range;
  logic             wr_writable;
  logic             wr_en;
  logic [NUM_REGS-1:0] pulse_next;

  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic [31:0]      rd_val;

  logic             addr_lsb_unused;
  assign addr_lsb_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Register image seen by readers and by reg_out.
  always_comb begin
    regs_view[0] = ID_VALUE;
    regs_view[1] = status_q;
    for (int unsigned i = 2; i < NUM_REGS; i++) begin
      regs_view[i] = rw_regs[i];
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[32*i +: 32] = regs_view[i];
    end
  end

  // ---------------- write channel ----------------
  always_ff @(posedge sys_clk) begin
    if (sys_reset) w_state <= W_IDLE;
    else           w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        if (s_axi_awvalid && s_axi_wvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (s_axi_awvalid) begin
          w_next = W_ADDR;
        end else if (s_axi_wvalid) begin
          w_next = W_DATA;
        end
      end
      W_ADDR: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_DATA: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // The completing handshake may come from either channel: take the half
  // captured earlier from the holding register and the other half live.
  always_comb begin
    wr_idx  = (w_state == W_ADDR) ? aw_idx_q : s_axi_awaddr[ADDR_W-1:2];
    wr_data = (w_state == W_DATA) ? w_data_q : s_axi_wdata;
    wr_strb = (w_state == W_DATA) ? w_strb_q : s_axi_wstrb;
    wr_in_range = {1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS);
    wr_writable = wr_in_range && (wr_idx >= IDX_W'(2));
    wr_en       = commit && wr_writable;
    pulse_next  = '0;
    for (int unsigned i = 2; i < NUM_REGS; i++) begin
      if (wr_en && wr_idx == IDX_W'(i)) pulse_next[i] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      aw_idx_q    <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      status_q    <= '0;
      wr_pulse    <= '0;
      s_axi_bresp <= '0;
      for (int unsigned i = 2; i < NUM_REGS; i++) rw_regs[i] <= '0;
    end else begin
      status_q <= status_in;
      wr_pulse <= pulse_next;
      if (s_axi_awready && s_axi_awvalid) aw_idx_q <= s_axi_awaddr[ADDR_W-1:2];
      if (s_axi_wready && s_axi_wvalid) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      for (int unsigned i = 2; i < NUM_REGS; i++) begin
        if (pulse_next[i]) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (wr_strb[b]) rw_regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      if (commit) begin
`ifdef AXIL_RESP_SLVERR_EN
        s_axi_bresp <= wr_writable ? 2'b00 : 2'b10;
`else
        s_axi_bresp <= 2'b00;
`endif
      end
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge sys_clk) begin
    if (sys_reset) r_state <= R_IDLE;
    else           r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_idx      = s_axi_araddr[ADDR_W-1:2];
    rd_in_range = {1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS);
    rd_val      = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val = regs_view[i];
    end
  end

  // Sampling regs_view at the handshake edge returns the pre-write value
  // when a write commits to the same register in that cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
    end else if (s_axi_arready && s_axi_arvalid) begin
      s_axi_rdata <= rd_in_range ? rd_val : 32'h0;
`ifdef AXIL_RESP_SLVERR_EN
      s_axi_rresp <= rd_in_range ? 2'b00 : 2'b10;
`else
      s_axi_rresp <= 2'b00;
`endif
    end
  end

endmodule

// File: tb/tb_axil_regfile_responder.sv
// Directed self-checking bench for axil_regfile_responder (default parameters).
module tb_axil_regfile_responder;

  localparam logic [31:0] ID = 32'h58475341;
`ifdef AXIL_RESP_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr;
  logic [31:0] wdata, rdata, status;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [511:0] reg_out;
  logic [15:0] wr_pulse;

  int checks = 0;
  int errors = 0;

  axil_regfile_responder #(.NUM_REGS(16), .ADDR_W(8), .ID_VALUE(ID)) dut (
    .sys_clk(clk), .sys_reset(rst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .status_in(status), .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write with AW and W presented together.
  task automatic axi_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [15:0] exp_pulse,
                           input logic [1:0] exp_resp);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, ".bvalid"}, bvalid, 1);
    chk({tag, ".wr_pulse"}, wr_pulse, exp_pulse);
    chk({tag, ".bresp"}, bresp, exp_resp);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk({tag, ".pulse_clear"}, wr_pulse, 0);
    chk({tag, ".awready_back"}, awready, 1);
  endtask

  task automatic axi_read(input string tag, input logic [7:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    arvalid = 1'b1; araddr = a;
    step();
    arvalid = 1'b0;
    chk({tag, ".rvalid"}, rvalid, 1);
    chk({tag, ".arready_busy"}, arready, 0);
    chk({tag, ".rdata"}, rdata, exp_data);
    chk({tag, ".rresp"}, rresp, exp_resp);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk({tag, ".rvalid_drop"}, rvalid, 0);
  endtask

  initial begin
    logic [511:0] exp_img;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; status = 0;
    step(); step();
    rst = 1'b0;
    step();

    chk("rst.awready", awready, 1);
    chk("rst.wready", wready, 1);
    chk("rst.arready", arready, 1);
    chk("rst.bvalid", bvalid, 0);
    chk("rst.rvalid", rvalid, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.bresp", bresp, 0);
    chk("rst.rresp", rresp, 0);
    chk("rst.wr_pulse", wr_pulse, 0);

    axi_read("rd_id", 8'h00, ID, 2'b00);
    axi_read("rd_r2_init", 8'h08, 32'h0, 2'b00);

    axi_write("wr_r2", 8'h08, 32'hA5A5_1234, 4'hF, 16'h0004, 2'b00);
    axi_read("rd_r2", 8'h08, 32'hA5A5_1234, 2'b00);
    chk("img_r2", reg_out[64 +: 32], 32'hA5A5_1234);

    // W leads AW by three cycles, partial strobe.
    axi_write("wr_r3_init", 8'h0C, 32'h1111_1111, 4'hF, 16'h0008, 2'b00);
    wvalid = 1'b1; wdata = 32'h0000_BB00; wstrb = 4'b0010;
    step();
    wvalid = 1'b0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    chk("wfirst.wready", wready, 0);
    chk("wfirst.awready", awready, 1);
    chk("wfirst.bvalid", bvalid, 0);
    step(); step();
    awvalid = 1'b1; awaddr = 8'h0C;
    step();
    awvalid = 1'b0;
    chk("wfirst.bvalid_set", bvalid, 1);
    chk("wfirst.pulse", wr_pulse, 16'h0008);
    // Backpressure on B for five cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bhold.bvalid", bvalid, 1);
      chk("bhold.bresp", bresp, 0);
      chk("bhold.awready", awready, 0);
      chk("bhold.wready", wready, 0);
      chk("bhold.pulse", wr_pulse, 0);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bhold.released", bvalid, 0);
    axi_read("rd_r3", 8'h0C, 32'h1111_BB11, 2'b00);

    // AW leads W.
    awvalid = 1'b1; awaddr = 8'h10;
    step();
    awvalid = 1'b0; awaddr = 8'h00;
    chk("awfirst.awready", awready, 0);
    chk("awfirst.wready", wready, 1);
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
    step();
    wvalid = 1'b0;
    chk("awfirst.pulse", wr_pulse, 16'h0010);
    bready = 1'b1;
    step();
    bready = 1'b0;
    axi_read("rd_r4", 8'h10, 32'h1234_5678, 2'b00);

    // Read-only and out-of-range writes change nothing.
    axi_write("wr_r0", 8'h00, 32'hDEAD_0000, 4'hF, 16'h0000, ERR_RESP);
    axi_write("wr_r1", 8'h04, 32'hDEAD_0001, 4'hF, 16'h0000, ERR_RESP);
    axi_write("wr_oor", 8'h40, 32'hDEAD_0040, 4'hF, 16'h0000, ERR_RESP);
    axi_read("rd_id_again", 8'h00, ID, 2'b00);

    // Top register vs first out-of-range index; addr[1:0] ignored.
    axi_write("wr_r15", 8'h3F, 32'hCAFE_0015, 4'hF, 16'h8000, 2'b00);
    axi_read("rd_r15", 8'h3C, 32'hCAFE_0015, 2'b00);
    axi_read("rd_oor", 8'h40, 32'h0, ERR_RESP);

    // Status sampling into register 1.
    status = 32'hC0FF_EE01;
    step(); step();
    chk("img_status", reg_out[32 +: 32], 32'hC0FF_EE01);
    axi_read("rd_status", 8'h04, 32'hC0FF_EE01, 2'b00);

    // Read and write to the same register in one cycle: read sees old value.
    arvalid = 1'b1; araddr = 8'h08;
    awvalid = 1'b1; awaddr = 8'h08; wvalid = 1'b1; wdata = 32'h0000_0077; wstrb = 4'hF;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("coll.rdata_old", rdata, 32'hA5A5_1234);
    chk("coll.bvalid", bvalid, 1);
    chk("coll.pulse", wr_pulse, 16'h0004);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    axi_read("rd_r2_new", 8'h08, 32'h0000_0077, 2'b00);

    // Reset while a read response is stalled.
    status = 32'h0;
    arvalid = 1'b1; araddr = 8'h00;
    step();
    arvalid = 1'b0;
    chk("prerst.rvalid", rvalid, 1);
    rst = 1'b1;
    step();
    exp_img = '0;
    exp_img[31:0] = ID;
    chk("midrst.rvalid", rvalid, 0);
    chk("midrst.arready", arready, 1);
    chk("midrst.rdata", rdata, 0);
    chk("midrst.reg_out", reg_out, exp_img);
    rst = 1'b0;
    step();
    chk("postrst.awready", awready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
